// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mc_pkg;

   // Controller states, one per datapath step.
   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_LUI,
      S_HALT
   } state_t;

   // ALU operation codes driven onto alu_ctrl.
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   // Immediate formats for the sign extender.
   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   // Register-file write-back source.
   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00,
      RES_MEM    = 2'b01,
      RES_ALU    = 2'b10,
      RES_IMM    = 2'b11
   } result_src_t;

   // How the ALU decoder should interpret funct3/funct7b5 in the current state.
   typedef enum logic [1:0] {
      CLS_ADD,
      CLS_BRANCH,
      CLS_REG,
      CLS_IMM
   } alu_class_t;

   // ALU operand selects.
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // Supported major opcodes.
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   // funct3 values the controller understands.
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/alu_decoder.sv
// Maps the state class and instruction function bits to an ALU operation,
// flagging function codes the core does not implement.
module alu_decoder
   import mc_pkg::*;
(
   input  alu_class_t cls,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output alu_ctrl_t  alu_ctrl,
   output logic       illegal
);

   // Pure lookup: add by default, sub for branches, funct3 table for ALU ops.
   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = 1'b0;
      unique case (cls)
         CLS_BRANCH: begin
            alu_ctrl = ALU_SUB;
            illegal  = !(funct3 == F3_BEQ || funct3 == F3_BNE);
         end
         CLS_REG, CLS_IMM: begin
            case (funct3)
               F3_ADD:  alu_ctrl = (cls == CLS_REG && funct7b5) ? ALU_SUB : ALU_ADD;
               F3_SLT:  alu_ctrl = ALU_SLT;
               F3_OR:   alu_ctrl = ALU_OR;
               F3_AND:  alu_ctrl = ALU_AND;
               default: illegal  = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I datapath sharing one memory port.
// Outputs are decoded from the state; only mem_ready, zero and the opcode
// fields feed same-cycle enables. Write enables are suppressed while rst is high.
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] result_src,
   output logic [2:0] imm_src,
   output logic       retire,
   output logic       halted
);

   state_t     state, state_next;
   logic [7:0] wait_cnt;
   logic       wait_expire;
   alu_class_t alu_cls;
   alu_ctrl_t  alu_dec;
   logic       alu_illegal;
   logic       mem_write_en, pc_en, ir_en, reg_en, retire_en;

   alu_decoder u_alu_decoder (
      .cls      (alu_cls),
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .alu_ctrl (alu_dec),
      .illegal  (alu_illegal)
   );

   // One more unanswered request cycle would reach the timeout limit.
   assign wait_expire = ({1'b0, wait_cnt} + 9'd1) >= 9'(MEM_TIMEOUT);

   // Select how the ALU decoder interprets funct3 for the current state.
   always_comb begin
      unique case (state)
         S_EXECR:  alu_cls = CLS_REG;
         S_EXECI:  alu_cls = CLS_IMM;
         S_BRANCH: alu_cls = CLS_BRANCH;
         default:  alu_cls = CLS_ADD;
      endcase
   end

   // State register with synchronous reset to FETCH.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   // Memory wait counter: counts unanswered request cycles within one state.
   always_ff @(posedge clk) begin
      if (rst || mem_ready || !mem_req || state_next != state) wait_cnt <= '0;
      else                                                    wait_cnt <= wait_cnt + 8'd1;
   end

   // Next-state and per-state datapath control decode.
   always_comb begin
      state_next   = state;
      mem_req      = 1'b0;
      mem_write_en = 1'b0;
      adr_src      = 1'b0;
      pc_en        = 1'b0;
      ir_en        = 1'b0;
      reg_en       = 1'b0;
      retire_en    = 1'b0;
      halted       = 1'b0;
      alu_src_a    = SRCA_PC;
      alu_src_b    = SRCB_RS2;
      alu_ctrl     = alu_dec;
      result_src   = RES_ALUOUT;
      imm_src      = IMM_I;

      unique case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_en      = 1'b1;
               pc_en      = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is computed here and parked in ALUOut.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_B;
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECR;
               OP_I:         state_next = S_EXECI;
               OP_B:         state_next = S_BRANCH;
               OP_JAL:       state_next = S_JAL;
               OP_LUI:       state_next = S_LUI;
               default:      state_next = S_HALT;
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            imm_src    = (op == OP_SW) ? IMM_S : IMM_I;
            state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            reg_en     = 1'b1;
            result_src = RES_MEM;
            retire_en  = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWR: begin
            mem_req      = 1'b1;
            mem_write_en = 1'b1;
            adr_src      = 1'b1;
            if (mem_ready) begin
               retire_en  = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXECR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            state_next = alu_illegal ? S_HALT : S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            imm_src    = IMM_I;
            state_next = alu_illegal ? S_HALT : S_ALUWB;
         end
         S_ALUWB: begin
            reg_en     = 1'b1;
            result_src = RES_ALUOUT;
            retire_en  = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            imm_src    = IMM_B;
            result_src = RES_ALUOUT;
            if (alu_illegal) begin
               state_next = S_HALT;
            end else begin
               pc_en      = (funct3 == F3_BEQ) ? zero : !zero;
               retire_en  = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_JAL: begin
            // Link value OldPC+4 goes to rd; the PC takes OldPC+J-imm from the target adder.
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            imm_src    = IMM_J;
            result_src = RES_ALU;
            reg_en     = 1'b1;
            pc_en      = 1'b1;
            retire_en  = 1'b1;
            state_next = S_FETCH;
         end
         S_LUI: begin
            imm_src    = IMM_U;
            result_src = RES_IMM;
            reg_en     = 1'b1;
            retire_en  = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_next = S_HALT;
      endcase

      // A memory that never answers traps the core instead of hanging it.
      if (mem_req && !mem_ready && wait_expire) state_next = S_HALT;
   end

   // Nothing is written or retired during a reset cycle.
   assign mem_write = mem_write_en & ~rst;
   assign pc_write  = pc_en        & ~rst;
   assign ir_write  = ir_en        & ~rst;
   assign reg_write = reg_en       & ~rst;
   assign retire    = retire_en    & ~rst;

endmodule
